// File: rtl/seq_code_checker.sv
// Downstream monitor for the 5-state Moore sequencer: predicts the next legal code,
// flags illegal or out-of-order codes, counts completed loops and errors, latches a fault.
module seq_code_checker #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [2:0]       code_in,
    input  logic             a_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] loop_cnt,
    output logic             fault,
    output logic [2:0]       exp_code
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ERR_LIM_C = CNT_W'(ERR_LIMIT);

    state_t           state_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] loop_cnt_q;
    logic             fault_q;
    logic [2:0]       exp_code_q;

    logic [CNT_W-1:0] err_cnt_d;
    logic [2:0]       exp_code_d;
    logic             code_legal;

    // Successor of a code in the legal graph; 0 marks "no legal successor".
    function automatic logic [2:0] next_code(input logic [2:0] code, input logic a);
        case (code)
            3'd2:    next_code = 3'd6;
            3'd6:    next_code = a ? 3'd3 : 3'd5;
            3'd5:    next_code = 3'd4;
            3'd4:    next_code = a ? 3'd6 : 3'd2;
            3'd3:    next_code = 3'd5;
            default: next_code = 3'd0;
        endcase
    endfunction

    always_comb begin
        err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        exp_code_d = next_code(code_in, a_in);
        code_legal = (code_in >= 3'd2) && (code_in <= 3'd6);
    end

    // The held prediction doubles as the exp_code output; a match against it
    // while locked implies the observed code is legal.
    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q     <= ST_IDLE;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            fault_q     <= 1'b0;
            exp_code_q  <= 3'd0;
        end else begin
            err_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && code_in == 3'd2) begin
                        state_q    <= ST_LOCKED;
                        locked_q   <= 1'b1;
                        exp_code_q <= 3'd6;
                    end
                end
                ST_LOCKED: begin
                    if (!in_valid) begin
                        state_q    <= ST_IDLE;
                        locked_q   <= 1'b0;
                        exp_code_q <= 3'd0;
                    end else if (code_in == exp_code_q) begin
                        exp_code_q <= exp_code_d;
                        if (code_in == 3'd2) loop_cnt_q <= loop_cnt_q + CNT_W'(1);
                    end else begin
                        err_pulse_q <= 1'b1;
                        err_cnt_q   <= err_cnt_d;
                        if (err_cnt_d == ERR_LIM_C) begin
                            state_q    <= ST_FAULT;
                            fault_q    <= 1'b1;
                            locked_q   <= 1'b0;
                            exp_code_q <= 3'd0;
                        end else if (!code_legal) begin
                            state_q    <= ST_IDLE;
                            locked_q   <= 1'b0;
                            exp_code_q <= 3'd0;
                        end else begin
                            exp_code_q <= exp_code_d;
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_q    <= ST_IDLE;
                    locked_q   <= 1'b0;
                    exp_code_q <= 3'd0;
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign loop_cnt  = loop_cnt_q;
    assign fault     = fault_q;
    assign exp_code  = exp_code_q;

endmodule

// File: tb/tb_seq_code_checker.sv
// Directed bench for seq_code_checker: hand-computed expected outputs after each
// clock edge, with default parameters (CNT_W=8, ERR_LIMIT=4).
module tb_seq_code_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] code_in = 3'd0;
    logic       a_in = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] loop_cnt;
    logic       fault;
    logic [2:0] exp_code;

    int n_checks = 0;
    int n_errors = 0;

    seq_code_checker #(.CNT_W(8), .ERR_LIMIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .code_in  (code_in),
        .a_in     (a_in),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .loop_cnt (loop_cnt),
        .fault    (fault),
        .exp_code (exp_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drive one sample on the falling edge; return 1 ns after the next rising edge.
    task automatic send(input logic v, input logic [2:0] c, input logic a);
        @(negedge clk);
        in_valid = v;
        code_in  = c;
        a_in     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic lk, input logic ep,
                             input int ec, input int lc, input logic f, input logic [2:0] ex);
        check({tag, ".locked"},    32'(locked),    32'(lk));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
        check({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
        check({tag, ".loop_cnt"},  32'(loop_cnt),  32'(lc));
        check({tag, ".fault"},     32'(fault),     32'(f));
        check({tag, ".exp_code"},  32'(exp_code),  32'(ex));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send(1'b1, 3'd2, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // 1: basic loop with a=0
        do_reset();
        check_all("t1_reset", 0, 0, 0, 0, 0, 3'd0);
        send(1, 3'd2, 0); check_all("t1_lock", 1, 0, 0, 0, 0, 3'd6);
        send(1, 3'd6, 0); check("t1_exp5", 32'(exp_code), 5);
        send(1, 3'd5, 0); check("t1_exp4", 32'(exp_code), 4);
        send(1, 3'd4, 0); check("t1_exp2", 32'(exp_code), 2);
        send(1, 3'd2, 0); check_all("t1_loop", 1, 0, 0, 1, 0, 3'd6);

        // 2: a=1 branches, exp_code 6,3,5,4,6,5,4
        do_reset();
        send(1, 3'd2, 0); check_all("t2_s0", 1, 0, 0, 0, 0, 3'd6);
        send(1, 3'd6, 1); check_all("t2_s1", 1, 0, 0, 0, 0, 3'd3);
        send(1, 3'd3, 0); check_all("t2_s2", 1, 0, 0, 0, 0, 3'd5);
        send(1, 3'd5, 0); check_all("t2_s3", 1, 0, 0, 0, 0, 3'd4);
        send(1, 3'd4, 1); check_all("t2_s4", 1, 0, 0, 0, 0, 3'd6);
        send(1, 3'd6, 0); check_all("t2_s5", 1, 0, 0, 0, 0, 3'd5);
        send(1, 3'd5, 1); check_all("t2_s6", 1, 0, 0, 0, 0, 3'd4);

        // 3: out-of-order legal code then resync
        do_reset();
        send(1, 3'd2, 0);
        send(1, 3'd6, 0);
        send(1, 3'd4, 0); check_all("t3_err", 1, 1, 1, 0, 0, 3'd2);
        send(1, 3'd2, 0); check_all("t3_resync2", 1, 0, 1, 1, 0, 3'd6);
        send(1, 3'd6, 0); check_all("t3_resync6", 1, 0, 1, 1, 0, 3'd5);

        // 4: illegal code drops lock, relock, valid gap drops lock silently
        send(1, 3'd7, 0); check_all("t4_illegal", 0, 1, 2, 1, 0, 3'd0);
        send(1, 3'd5, 0); check_all("t4_idle_ign", 0, 0, 2, 1, 0, 3'd0);
        send(1, 3'd2, 0); check_all("t4_relock", 1, 0, 2, 1, 0, 3'd6);
        send(1, 3'd6, 1); check_all("t4_run", 1, 0, 2, 1, 0, 3'd3);
        send(0, 3'd0, 0); check_all("t4_gap", 0, 0, 2, 1, 0, 3'd0);

        // 5: four errors reach ERR_LIMIT
        do_reset();
        send(1, 3'd2, 0);
        send(1, 3'd5, 0); check_all("t5_e1", 1, 1, 1, 0, 0, 3'd4);
        send(1, 3'd3, 0); check_all("t5_e2", 1, 1, 2, 0, 0, 3'd5);
        send(1, 3'd2, 0); check_all("t5_e3", 1, 1, 3, 0, 0, 3'd6);
        send(1, 3'd4, 0); check_all("t5_e4", 0, 1, 4, 0, 1, 3'd0);
        send(1, 3'd2, 0); check_all("t5_hold1", 0, 0, 4, 0, 1, 3'd0);
        send(1, 3'd7, 0); check_all("t5_hold2", 0, 0, 4, 0, 1, 3'd0);
        clear = 1'b1;
        send(1, 3'd7, 0); check_all("t5_clear", 0, 0, 0, 0, 0, 3'd0);
        clear = 1'b0;

        // 6: reset mid-stream, then clear coinciding with an error
        send(1, 3'd2, 0);
        send(1, 3'd6, 0); check_all("t6_pre", 1, 0, 0, 0, 0, 3'd5);
        reset = 1'b1;
        send(1, 3'd5, 0); check_all("t6_reset", 0, 0, 0, 0, 0, 3'd0);
        reset = 1'b0;
        send(1, 3'd6, 0); check_all("t6_nolock", 0, 0, 0, 0, 0, 3'd0);
        send(1, 3'd2, 0); check_all("t6_relock", 1, 0, 0, 0, 0, 3'd6);
        send(1, 3'd6, 0);
        clear = 1'b1;
        send(1, 3'd4, 0); check_all("t6_clr_err", 0, 0, 0, 0, 0, 3'd0);
        clear = 1'b0;

        // 7: loop_cnt wraps modulo 256 with no error
        do_reset();
        send(1, 3'd2, 0);
        for (int i = 0; i < 255; i++) begin
            send(1, 3'd6, 0);
            send(1, 3'd5, 0);
            send(1, 3'd4, 0);
            send(1, 3'd2, 0);
        end
        check_all("t7_255", 1, 0, 0, 255, 0, 3'd6);
        send(1, 3'd6, 0);
        send(1, 3'd5, 0);
        send(1, 3'd4, 0);
        send(1, 3'd2, 0);
        check_all("t7_wrap", 1, 0, 0, 0, 0, 3'd6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
